pit_access_master: RTL

Bus-side initiator for the 8254-style programmable interval timer in the SoC. It converts single high-level commands into the byte-serial I/O sequences the timer counters respond to: program a counter, latch and read a count, or read back status. It sits between an internal requester (BIOS-assist / timer calibration logic) and the timer's 4-port I/O window: ports 0–2 are counters, port 3 is the control register.

---
 rtl/pit_access_master_if.sv | 31 +++
 rtl/pit_access_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pit_access_master_if.sv
// Command, response and timer I/O window signals of pit_access_master.
// The master modport is the sequencer side; slave is the requester/timer side.
interface pit_access_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_counter;
    logic [2:0]  cmd_mode;
    logic        cmd_bcd;
    logic [15:0] cmd_value;
    logic        rsp_valid;
    logic        rsp_error;
    logic [15:0] rsp_data;
    logic [1:0]  io_address;
    logic        io_write;
    logic        io_read;
    logic [7:0]  io_writedata;
    logic [7:0]  io_readdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_counter, cmd_mode, cmd_bcd, cmd_value, io_readdata,
        output cmd_ready, rsp_valid, rsp_error, rsp_data,
        output io_address, io_write, io_read, io_writedata
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_counter, cmd_mode, cmd_bcd, cmd_value, io_readdata,
        input  cmd_ready, rsp_valid, rsp_error, rsp_data,
        input  io_address, io_write, io_read, io_writedata
    );
endinterface

// File: rtl/pit_access_master.sv
// Turns program / read-count / read-status commands into 8254 byte-serial I/O sequences.
// Optional LSB-only (RW=01) handling is enabled by defining PIT_ACCESS_SHORT_EN.
module pit_access_master #(
    parameter int unsigned ACCESS_GAP = 1
) (
    input  logic                clk,
    input  logic                rst,
    pit_access_master_if.master bus
);
    localparam int unsigned GAP_W      = 4;
    localparam int unsigned NUM_CTR    = 3;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(ACCESS_GAP - 1);

    localparam logic [1:0] OP_PROG   = 2'd0;
    localparam logic [1:0] OP_COUNT  = 2'd1;
    localparam logic [1:0] OP_STATUS = 2'd2;
    localparam logic [1:0] OP_ERR    = 2'd3;
    localparam logic [1:0] CTRL_PORT = 2'd3;
    localparam logic [1:0] BAD_CTR   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CTRL,
        S_GAP,
        S_BYTE_L,
        S_BYTE_H,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               hi_phase_q, hi_phase_d;
    logic [1:0]         op_q, op_d;
    logic [1:0]         ctr_q, ctr_d;
    logic [15:0]        value_q, value_d;
    logic               single_q, single_d;
    logic [7:0]         lsb_q, lsb_d;
    logic [NUM_CTR-1:0] short_q, short_d;

    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_error_q, rsp_error_d;
    logic [15:0]        rsp_data_q, rsp_data_d;
    logic [1:0]         io_address_q, io_address_d;
    logic               io_write_q, io_write_d;
    logic               io_read_q, io_read_d;
    logic [7:0]         io_writedata_q, io_writedata_d;

    logic               accept_c;
    logic               cmd_err_c;
    logic               prog_short_c;
    logic               cnt_short_c;
    logic               single_c;
    logic [7:0]         ctrl_byte_c;

    // Decode the incoming command into its control-port byte and sequence length.
    always_comb begin
        accept_c     = bus.cmd_valid && cmd_ready_q;
        cmd_err_c    = (bus.cmd_op == OP_ERR) || (bus.cmd_counter == BAD_CTR);
        prog_short_c = 1'b0;
        cnt_short_c  = 1'b0;
        ctrl_byte_c  = 8'h00;
        single_c     = 1'b0;
`ifdef PIT_ACCESS_SHORT_EN
        prog_short_c = (bus.cmd_value[15:8] == 8'h00);
        for (int i = 0; i < int'(NUM_CTR); i++) begin
            if (bus.cmd_counter == 2'(i)) begin
                cnt_short_c = short_q[i];
            end
        end
`endif
        case (bus.cmd_op)
            OP_PROG: begin
                ctrl_byte_c = {bus.cmd_counter, (prog_short_c ? 2'b01 : 2'b11),
                               bus.cmd_mode, bus.cmd_bcd};
                single_c    = prog_short_c;
            end
            OP_COUNT: begin
                ctrl_byte_c = {bus.cmd_counter, 6'b000000};
                single_c    = cnt_short_c;
            end
            OP_STATUS: begin
                ctrl_byte_c = 8'hE0 | (8'h02 << bus.cmd_counter);
                single_c    = 1'b1;
            end
            default: begin
                ctrl_byte_c = 8'h00;
                single_c    = 1'b0;
            end
        endcase
    end

    // Next-state and registered-output logic; strobes are set on entry to their state.
    always_comb begin
        state_d        = state_q;
        gap_cnt_d      = gap_cnt_q;
        hi_phase_d     = hi_phase_q;
        op_d           = op_q;
        ctr_d          = ctr_q;
        value_d        = value_q;
        single_d       = single_q;
        lsb_d          = lsb_q;
        short_d        = short_q;
        rsp_valid_d    = 1'b0;
        rsp_error_d    = 1'b0;
        rsp_data_d     = rsp_data_q;
        io_address_d   = io_address_q;
        io_write_d     = 1'b0;
        io_read_d      = 1'b0;
        io_writedata_d = io_writedata_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    op_d     = bus.cmd_op;
                    ctr_d    = bus.cmd_counter;
                    value_d  = bus.cmd_value;
                    single_d = single_c;
                    if (cmd_err_c) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_data_d  = 16'h0000;
                    end else begin
                        state_d        = S_CTRL;
                        io_write_d     = 1'b1;
                        io_address_d   = CTRL_PORT;
                        io_writedata_d = ctrl_byte_c;
                        if (bus.cmd_op == OP_PROG) begin
                            for (int i = 0; i < int'(NUM_CTR); i++) begin
                                if (bus.cmd_counter == 2'(i)) begin
                                    short_d[i] = prog_short_c;
                                end
                            end
                        end
                    end
                end
            end
            S_CTRL: begin
                state_d    = S_GAP;
                hi_phase_d = 1'b0;
                gap_cnt_d  = GAP_RELOAD;
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d      = hi_phase_q ? S_BYTE_H : S_BYTE_L;
                    io_address_d = ctr_q;
                    if (op_q == OP_PROG) begin
                        io_write_d     = 1'b1;
                        io_writedata_d = hi_phase_q ? value_q[15:8] : value_q[7:0];
                    end else begin
                        io_read_d = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            S_BYTE_L: begin
                // io_readdata is only valid in the cycle our read strobe is high.
                lsb_d = bus.io_readdata;
                if (single_q) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = (op_q == OP_PROG) ? 16'h0000 : {8'h00, bus.io_readdata};
                end else begin
                    state_d    = S_GAP;
                    hi_phase_d = 1'b1;
                    gap_cnt_d  = GAP_RELOAD;
                end
            end
            S_BYTE_H: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = (op_q == OP_PROG) ? 16'h0000 : {bus.io_readdata, lsb_q};
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            gap_cnt_q      <= '0;
            hi_phase_q     <= 1'b0;
            op_q           <= OP_PROG;
            ctr_q          <= 2'd0;
            value_q        <= 16'h0000;
            single_q       <= 1'b0;
            lsb_q          <= 8'h00;
            short_q        <= '0;
            cmd_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_error_q    <= 1'b0;
            rsp_data_q     <= 16'h0000;
            io_address_q   <= 2'd0;
            io_write_q     <= 1'b0;
            io_read_q      <= 1'b0;
            io_writedata_q <= 8'h00;
        end else begin
            state_q        <= state_d;
            gap_cnt_q      <= gap_cnt_d;
            hi_phase_q     <= hi_phase_d;
            op_q           <= op_d;
            ctr_q          <= ctr_d;
            value_q        <= value_d;
            single_q       <= single_d;
            lsb_q          <= lsb_d;
            short_q        <= short_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_error_q    <= rsp_error_d;
            rsp_data_q     <= rsp_data_d;
            io_address_q   <= io_address_d;
            io_write_q     <= io_write_d;
            io_read_q      <= io_read_d;
            io_writedata_q <= io_writedata_d;
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_error    = rsp_error_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.io_address   = io_address_q;
    assign bus.io_write     = io_write_q;
    assign bus.io_read      = io_read_q;
    assign bus.io_writedata = io_writedata_q;
endmodule
